// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences start/stop, lap freeze and clear for the
// BCD time counter, gates the time-base tick into the counter and parks the
// counter at its maximum value instead of letting it wrap.
module stopwatch_ctrl #(
    parameter int LAP_HOLD_TICKS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    input  logic       wrap,
    output logic       count_en,
    output logic       count_clr,
    output logic       snap,
    output logic       freeze,
    output logic       running,
    output logic [2:0] state
);

    localparam int TW = $clog2(LAP_HOLD_TICKS + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(LAP_HOLD_TICKS);
    localparam logic [TW-1:0] HOLD_ONE  = TW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSE     = 3'd2,
        RUN_LAP   = 3'd3,
        PAUSE_LAP = 3'd4,
        SAT       = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   hold_q, hold_d;
    logic            clr_q, clr_d;
    logic            snap_q, snap_d;

    // Next-state logic; each branch chain encodes the event priority
    // clear > tick&wrap > start_stop > lap > hold expiry, with inputs that a
    // state ignores simply absent from its chain so they never block others.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        clr_d   = 1'b0;
        snap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    clr_d = 1'b1;
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick && wrap) begin
                    state_d = SAT;
                end else if (start_stop) begin
                    state_d = PAUSE;
                end else if (lap) begin
                    state_d = RUN_LAP;
                    snap_d  = 1'b1;
                    hold_d  = HOLD_LOAD;
                end
            end
            RUN_LAP: begin
                if (tick && wrap) begin
                    state_d = SAT;
                end else if (start_stop) begin
                    // Pausing takes precedence over a coincident tick, so the
                    // held count never reaches zero while frozen in PAUSE_LAP.
                    state_d = PAUSE_LAP;
                end else if (lap) begin
                    snap_d = 1'b1;
                    hold_d = HOLD_LOAD;
                end else if (tick) begin
                    if (hold_q <= HOLD_ONE) begin
                        hold_d  = '0;
                        state_d = RUN;
                    end else begin
                        hold_d = hold_q - HOLD_ONE;
                    end
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
            PAUSE_LAP: begin
                if (clear) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else if (start_stop) begin
                    state_d = RUN_LAP;
                end else if (lap) begin
                    state_d = PAUSE;
                end
            end
            SAT: begin
                if (clear) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, hold counter and registered command pulses; reset also kills
    // any pulse that was about to be issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            clr_q   <= 1'b0;
            snap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            clr_q   <= clr_d;
            snap_q  <= snap_d;
        end
    end

    // Outputs decoded from the registered state; count_en is the only
    // combinational path from an input (tick/wrap) to an output.
    always_comb begin
        running   = (state_q == RUN) || (state_q == RUN_LAP);
        freeze    = (state_q == RUN_LAP) || (state_q == PAUSE_LAP);
        count_en  = tick && running && !wrap;
        count_clr = clr_q;
        snap      = snap_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a flag-based behavioural model of the
// stopwatch predicts the outputs for every clock cycle, a monitor compares.
module tb_stopwatch_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0, wrap = 1'b0;
    logic       count_en, count_clr, snap, freeze, running;
    logic [2:0] state;

    stopwatch_ctrl #(.LAP_HOLD_TICKS(N)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
        .lap(lap), .clear(clear), .wrap(wrap), .count_en(count_en),
        .count_clr(count_clr), .snap(snap), .freeze(freeze),
        .running(running), .state(state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cycle = 0;
    logic [7:0] expq[$];

    // Behavioural model: stopwatch described by flags, not by state codes.
    bit m_active = 0;   // has been started since the last clear
    bit m_run = 0;      // time is advancing
    bit m_lapf = 0;     // a lap snapshot is being displayed
    bit m_sat = 0;      // counter reached its maximum
    int m_hold = 0;     // ticks left until the lap display auto-releases
    bit m_clr_p = 0;    // clear pulse issued at the coming edge
    bit m_snap_p = 0;   // snapshot pulse issued at the coming edge

    function automatic logic [2:0] m_code();
        if (m_sat) return 3'd5;
        if (!m_active) return 3'd0;
        if (m_run) return m_lapf ? 3'd3 : 3'd1;
        return m_lapf ? 3'd4 : 3'd2;
    endfunction

    task automatic cyc(input bit t, input bit s, input bit l, input bit c,
                       input bit w, input bit r);
        logic [7:0] e;
        bit nclr, nsnap;
        @(posedge clk);
        #2;
        reset = r; tick = t; start_stop = s; lap = l; clear = c; wrap = w;
        if (r) begin
            m_active = 0; m_run = 0; m_lapf = 0; m_sat = 0; m_hold = 0;
            m_clr_p = 0; m_snap_p = 0;
        end
        e = {m_code(), m_run, m_lapf, t & m_run & ~w, m_clr_p, m_snap_p};
        expq.push_back(e);
        nclr = 0; nsnap = 0;
        if (!r) begin
            if (!m_run && c) begin
                if (m_active) begin
                    m_active = 0; m_lapf = 0; m_sat = 0;
                end
                nclr = 1;
            end else if (m_run && t && w) begin
                m_sat = 1; m_run = 0; m_lapf = 0;
            end else if (m_sat) begin
                // everything else is ignored once saturated
            end else if (s) begin
                if (!m_active) begin
                    m_active = 1; m_run = 1;
                end else begin
                    m_run = !m_run;
                end
            end else if (l && m_active && (m_run || m_lapf)) begin
                if (m_run) begin
                    m_lapf = 1; m_hold = N; nsnap = 1;
                end else begin
                    m_lapf = 0;
                end
            end else if (m_run && m_lapf && t) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) m_lapf = 0;
            end
        end
        m_clr_p = nclr; m_snap_p = nsnap;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always begin
        logic [7:0] e, a;
        @(negedge clk);
        cycle++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {state, running, freeze, count_en, count_clr, snap};
            tests++;
            if (a !== e) begin
                failed++;
                $display("FAIL outputs cycle %0d {state,run,frz,cen,clr,snap}: got %b_%b%b%b%b%b want %b_%b%b%b%b%b",
                         cycle, a[7:5], a[4], a[3], a[2], a[1], a[0],
                         e[7:5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        bit w_hold;
        // reset state
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        idle(2);
        // start, five counted ticks, stop, ticks not counted
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 5; i++) begin cyc(1, 0, 0, 0, 0, 0); idle(1); end
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); idle(1);
        // lap auto-release after N ticks
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < N + 1; i++) begin cyc(1, 0, 0, 0, 0, 0); idle(2); end
        // relap, pause during lap, resume and release
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0); idle(1); cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0); idle(1); cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin cyc(1, 0, 0, 0, 0, 0); idle(1); end
        // lap reload coinciding with expiry, start_stop coinciding with expiry
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < N - 1; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < N - 1; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0); idle(1);
        // clear rules
        cyc(0, 0, 0, 1, 0, 0); idle(1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0); idle(2);
        cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0); idle(2);
        cyc(0, 1, 0, 1, 0, 0); idle(1);
        // saturation
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 1, 0); cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0); idle(1);
        // asynchronous reset mid-cycle during a lap, with snap pending
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        idle(2);
        // randomized traffic
        w_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) w_hold = !w_hold;
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                w_hold, $urandom_range(0, 499) == 0);
        end
        idle(2);
        @(negedge clk);
        #1;
        tests++;
        if (expq.size() != 0) begin
            failed++;
            $display("FAIL scoreboard drain: got %0d pending want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch datapath. Takes single-cycle pulses from the three debounced buttons (start/stop, lap, clear) and sequences the time counter: it gates the time-base tick into the counter, clears it, and commands the lap-display freeze/snapshot. It also halts counting at the counter's maximum value. It sits between the `debounce` instances and the BCD time counter / display register.

## Interface
- `LAP_HOLD_TICKS`, 300: number of `tick` pulses the lap snapshot stays frozen before auto-release (3 s at 100 Hz); must be ≥ 1.
- Internal localparam `TW = $clog2(LAP_HOLD_TICKS+1)`: width of the hold counter.

- `clk` in 1: system clock, all state on posedge.
- `reset` in 1: asynchronous, active-high; one clock, async active-high reset, as decided.
- `tick` in 1: time-base clock enable, one `clk` wide (100 Hz).
- `start_stop` in 1: debounced start/stop pulse, one `clk` wide.
- `lap` in 1: debounced lap pulse, one `clk` wide.
- `clear` in 1: debounced clear pulse, one `clk` wide.
- `wrap` in 1: from counter, high while count is at max (99:59.99).
- `count_en` out 1: counter increment enable.
- `count_clr` out 1: counter synchronous-clear pulse.
- `snap` out 1: pulse that loads the display snapshot register from the counter.
- `freeze` out 1: display shows the snapshot instead of the live count.
- `running` out 1: counter is advancing.
- `state` out 3: current FSM state, for debug.

## Operation
- States and encodings: IDLE=0, RUN=1, PAUSE=2, RUN_LAP=3, PAUSE_LAP=4, SAT=5. Codes 6–7 recover to IDLE on the next clock.
- **IDLE**
  - `start_stop` → RUN.
  - `clear` → pulse `count_clr`, stay in IDLE.
  - `lap` is ignored.
- **RUN**
  - `start_stop` → PAUSE.
  - `lap` → RUN_LAP, pulse `snap`, load hold counter with `LAP_HOLD_TICKS`.
  - `tick & wrap` → SAT.
  - `clear` is ignored.
- **RUN_LAP**
  - `lap` → stay in RUN_LAP, pulse `snap`, reload hold counter.
  - `start_stop` → PAUSE_LAP; the hold counter is frozen.
  - On `tick`, the hold counter decrements; a decrement to 0 → RUN.
  - `tick & wrap` → SAT.
- **PAUSE**
  - `start_stop` → RUN.
  - `clear` → IDLE and pulse `count_clr`.
  - `lap` is ignored.
- **PAUSE_LAP**
  - `lap` → PAUSE (releases the freeze).
  - `start_stop` → RUN_LAP; the hold counter resumes from its held value.
  - `clear` → IDLE and pulse `count_clr`.
- **SAT**
  - `clear` → IDLE and pulse `count_clr`.
  - All other inputs are ignored.
- Priority when events coincide in one cycle: first the effective `clear`, then `tick & wrap`, then `start_stop`, then `lap`, then hold-counter expiry. An input that is ignored in the current state does not block a lower-priority event.
- Lap-reload and expiry in the same cycle: the reload wins and the FSM stays in RUN_LAP.
- `start_stop` and expiry in the same cycle: go to PAUSE_LAP with no decrement, so the hold counter stays ≥ 1.
- Decoded outputs from the state register:
  - `running` = (state ∈ {RUN, RUN_LAP}).
  - `freeze` = (state ∈ {RUN_LAP, PAUSE_LAP}).
- `count_en = tick & running & ~wrap` (combinational). The counter never wraps.

## Timing
- Reset values: state IDLE; hold counter 0; `count_clr`, `snap`, `freeze`, `running` all 0. `count_en` is 0 because `running` is 0.
- Input sampled at edge N:
  - The state change is visible after edge N.
  - `count_clr` and `snap` are registered and high for exactly the one cycle after edge N.
- `count_en` has zero latency from `tick`. It is qualified by the registered state, so the first tick after a start is counted only if it arrives at least 1 cycle after the `start_stop` pulse.
- The hold counter changes only on `tick` cycles while in RUN_LAP. Auto-release occurs on the edge of the `LAP_HOLD_TICKS`-th tick after the last `snap`.
- Asserting `reset` mid-operation forces IDLE immediately (asynchronously) and kills any pending pulse. It does not clear the counter; software/user must press clear.

## Test plan
- **Reset and start:** reset, then `start_stop`, then 5 ticks.
  - Required: `running`=1, `count_en` high on exactly 5 cycles.
  - Second `start_stop`: state=2, no further `count_en`.
- **Lap auto-release:** `LAP_HOLD_TICKS`=4; from RUN, pulse `lap`.
  - Required: `snap` one cycle, `freeze`=1.
  - After the 4th tick: state=1, `freeze`=0. `count_en` continues throughout.
- **Relap and pause in lap:** in RUN_LAP after 2 ticks, pulse `lap`, and the counter reloads to 4. Then `start_stop` → state=4, ticks do not decrement. Then `start_stop` → state=3; release comes 2 ticks after the relap plus 2 more ticks.
- **Clear rules:**
  - `clear` in RUN: no `count_clr`, state stays 1.
  - `clear` in PAUSE: `count_clr` for 1 cycle, state=0.
  - `clear` and `start_stop` together in PAUSE: state=0, `count_clr`=1.
- **Saturation:** hold `wrap`=1 in RUN and tick.
  - Required: `count_en`=0 on that tick, state=5.
  - `start_stop` and `lap` are ignored; `clear` → state=0.
- **Async reset:** assert `reset` mid-cycle in RUN_LAP.
  - Required: state=0, `freeze`=0, `running`=0 before the next clock edge; `snap` is suppressed.
